// File: rtl/slice_hit_detector_pkg.sv
// ----------------------------------------------------------------------------
// slice_hit_detector_pkg
// Shared constants and types for the slice hit detector:
//   SCREEN_W / SCREEN_H : visible area; the cursor must lie inside it to hit
//   COORD_W             : pixel coordinate width
//   obj_state_t         : object state codes decoded from the NIOS ports
//   scan_state_t        : scan FSM states
// ----------------------------------------------------------------------------
package slice_hit_detector_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int COORD_W  = 10;

    typedef enum logic [2:0] {
        ST_EMPTY   = 3'd0,
        ST_LIVE    = 3'd1,
        ST_SLICED  = 3'd2,
        ST_FALLING = 3'd3
    } obj_state_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        SCAN   = 2'd2
    } scan_state_t;

endpackage

// File: rtl/slice_hit_detector_if.sv
// ----------------------------------------------------------------------------
// slice_hit_detector_if
// Hit-mask handshake between the detector and software.
//   hit_mask  : pending hits, bit i = object i       (detector -> software)
//   hit_valid : |hit_mask, registered with the mask   (detector -> software)
//   hit_ack   : one-cycle pulse, consumes the mask    (software -> detector)
// master = detector side, slave = software side.
// ----------------------------------------------------------------------------
interface slice_hit_detector_if #(
    parameter int NUM_OBJ = 8
);
    logic [NUM_OBJ-1:0] hit_mask;
    logic               hit_valid;
    logic               hit_ack;

    modport master (
        output hit_mask,
        output hit_valid,
        input  hit_ack
    );

    modport slave (
        input  hit_mask,
        input  hit_valid,
        output hit_ack
    );
endinterface

// File: rtl/slice_hit_detector_hit_box_compare.sv
// ----------------------------------------------------------------------------
// hit_box_compare
// Combinational test of one cursor position against one object hitbox.
//   i_cur_x / i_cur_y : cursor position
//   i_obj_x / i_obj_y : object centre
//   o_in_box          : cursor on-screen and within +/-HALF_W, +/-HALF_H
// Differences are formed one bit wider than the coordinates and signed, so a
// cursor near 0 never wraps onto an object near the top of the range.
// ----------------------------------------------------------------------------
module hit_box_compare #(
    parameter int COORD_W = 10,
    parameter int HALF_W  = 16,
    parameter int HALF_H  = 16
) (
    input  logic [COORD_W-1:0] i_cur_x,
    input  logic [COORD_W-1:0] i_cur_y,
    input  logic [COORD_W-1:0] i_obj_x,
    input  logic [COORD_W-1:0] i_obj_y,
    output logic               o_in_box
);
    import slice_hit_detector_pkg::*;

    localparam logic signed [COORD_W:0] LIM_X = (COORD_W+1)'(HALF_W);
    localparam logic signed [COORD_W:0] LIM_Y = (COORD_W+1)'(HALF_H);
    localparam logic [COORD_W:0]        MAX_X = (COORD_W+1)'(SCREEN_W);
    localparam logic [COORD_W:0]        MAX_Y = (COORD_W+1)'(SCREEN_H);

    logic signed [COORD_W:0] w_dx;
    logic signed [COORD_W:0] w_dy;
    logic signed [COORD_W:0] w_abs_dx;
    logic signed [COORD_W:0] w_abs_dy;
    logic                    w_on_screen;

    always_comb begin
        w_dx = $signed({1'b0, i_cur_x}) - $signed({1'b0, i_obj_x});
        w_dy = $signed({1'b0, i_cur_y}) - $signed({1'b0, i_obj_y});
        // Magnitude is at most 2^COORD_W-1, so negation cannot overflow.
        w_abs_dx    = (w_dx < 0) ? -w_dx : w_dx;
        w_abs_dy    = (w_dy < 0) ? -w_dy : w_dy;
        w_on_screen = ({1'b0, i_cur_x} < MAX_X) && ({1'b0, i_cur_y} < MAX_Y);
        o_in_box    = w_on_screen && (w_abs_dx <= LIM_X) && (w_abs_dy <= LIM_Y);
    end
endmodule

// File: rtl/slice_hit_detector.sv
// ----------------------------------------------------------------------------
// slice_hit_detector
// On each frame_tick, snapshots the cursor and all object coords/states, then
// walks the objects one per cycle and flags every live object the streaking
// cursor overlaps. Pending hits are handed to software over hit_bus.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   i_frame_tick     : one-cycle strobe starting a scan (ignored while busy)
//   i_cursorX/Y      : cursor position, i_streak = user is slicing
//   i_obj_x/y        : packed object centres, obj i at [i*COORD_W +: COORD_W]
//   i_obj_state      : packed object states,  obj i at [i*STATE_W +: STATE_W]
//   hit_bus          : hit_mask / hit_valid / hit_ack handshake
//   o_scan_busy      : snapshot or scan in progress
//   o_hit_count      : hits since reset, saturating at 16'hFFFF
// ----------------------------------------------------------------------------
module slice_hit_detector #(
    parameter int NUM_OBJ = 8,
    parameter int COORD_W = slice_hit_detector_pkg::COORD_W,
    parameter int STATE_W = 3,
    parameter int HALF_W  = 16,
    parameter int HALF_H  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_frame_tick,
    input  logic [COORD_W-1:0]         i_cursorX,
    input  logic [COORD_W-1:0]         i_cursorY,
    input  logic                       i_streak,
    input  logic [NUM_OBJ*COORD_W-1:0] i_obj_x,
    input  logic [NUM_OBJ*COORD_W-1:0] i_obj_y,
    input  logic [NUM_OBJ*STATE_W-1:0] i_obj_state,
    slice_hit_detector_if.master       hit_bus,
    output logic                       o_scan_busy,
    output logic [15:0]                o_hit_count
);
    import slice_hit_detector_pkg::*;

    localparam int                 IDX_W     = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_OBJ - 1);
    localparam logic [STATE_W-1:0] LIVE_CODE = STATE_W'(ST_LIVE);

    scan_state_t          r_state;
    scan_state_t          w_state_nxt;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic [NUM_OBJ-1:0]   r_hit_mask;
    logic [NUM_OBJ-1:0]   w_mask_nxt;
    logic [NUM_OBJ-1:0]   w_mask_set;
    logic [NUM_OBJ-1:0]   w_mask_clr;
    logic                 r_hit_valid;
    logic [15:0]          r_hit_count;
    logic [15:0]          w_count_nxt;
    logic                 w_hit;
    logic                 w_in_box;

    // Snapshot: data only, never reset; qualified by the FSM.
    logic [COORD_W-1:0]         r_snap_cx;
    logic [COORD_W-1:0]         r_snap_cy;
    logic                       r_snap_streak;
    logic [NUM_OBJ*COORD_W-1:0] r_snap_x;
    logic [NUM_OBJ*COORD_W-1:0] r_snap_y;
    logic [NUM_OBJ*STATE_W-1:0] r_snap_state;

    logic [COORD_W-1:0] w_cur_obj_x;
    logic [COORD_W-1:0] w_cur_obj_y;
    logic [STATE_W-1:0] w_cur_obj_state;

    assign w_cur_obj_x     = r_snap_x[r_idx*COORD_W +: COORD_W];
    assign w_cur_obj_y     = r_snap_y[r_idx*COORD_W +: COORD_W];
    assign w_cur_obj_state = r_snap_state[r_idx*STATE_W +: STATE_W];

    hit_box_compare #(
        .COORD_W (COORD_W),
        .HALF_W  (HALF_W),
        .HALF_H  (HALF_H)
    ) u_cmp (
        .i_cur_x  (r_snap_cx),
        .i_cur_y  (r_snap_cy),
        .i_obj_x  (w_cur_obj_x),
        .i_obj_y  (w_cur_obj_y),
        .o_in_box (w_in_box)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_hit       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_frame_tick) begin
                    w_state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                w_state_nxt = SCAN;
                w_idx_nxt   = '0;
            end
            SCAN: begin
                w_hit = r_snap_streak && (w_cur_obj_state == LIVE_CODE) &&
                        !r_hit_mask[r_idx] && w_in_box;
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = '0;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Ack consumes only the mask software could see; a hit landing in the
    // same cycle survives the ack.
    always_comb begin
        w_mask_set = '0;
        w_mask_clr = '0;
        if (w_hit) begin
            w_mask_set = NUM_OBJ'(1) << r_idx;
        end
        if (hit_bus.hit_ack && r_hit_valid) begin
            w_mask_clr = r_hit_mask;
        end
        w_mask_nxt  = (r_hit_mask & ~w_mask_clr) | w_mask_set;
        w_count_nxt = (w_hit && (r_hit_count != 16'hFFFF)) ? r_hit_count + 16'd1
                                                            : r_hit_count;
    end

    // ---- control registers ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_hit_mask  <= '0;
            r_hit_valid <= 1'b0;
            r_hit_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_hit_mask  <= w_mask_nxt;
            r_hit_valid <= |w_mask_nxt;
            r_hit_count <= w_count_nxt;
        end
    end

    // ---- snapshot registers, loaded in SAMPLE ----
    always_ff @(posedge clk) begin
        if (r_state == SAMPLE) begin
            r_snap_cx     <= i_cursorX;
            r_snap_cy     <= i_cursorY;
            r_snap_streak <= i_streak;
            r_snap_x      <= i_obj_x;
            r_snap_y      <= i_obj_y;
            r_snap_state  <= i_obj_state;
        end
    end

    assign hit_bus.hit_mask  = r_hit_mask;
    assign hit_bus.hit_valid = r_hit_valid;
    assign o_scan_busy       = (r_state != IDLE);
    assign o_hit_count       = r_hit_count;
endmodule

// File: tb/tb_slice_hit_detector.sv
module tb_slice_hit_detector;
    import slice_hit_detector_pkg::*;

    localparam int N  = 8;
    localparam int CW = 10;
    localparam int SW = 3;

    logic            clk;
    logic            reset;
    logic            i_frame_tick;
    logic [CW-1:0]   i_cursorX;
    logic [CW-1:0]   i_cursorY;
    logic            i_streak;
    logic [N*CW-1:0] i_obj_x;
    logic [N*CW-1:0] i_obj_y;
    logic [N*SW-1:0] i_obj_state;
    logic            o_scan_busy;
    logic [15:0]     o_hit_count;

    int n_chk = 0;
    int n_err = 0;
    int busy_n;

    slice_hit_detector_if #(.NUM_OBJ(N)) hit_bus ();

    slice_hit_detector #(
        .NUM_OBJ (N),
        .COORD_W (CW),
        .STATE_W (SW),
        .HALF_W  (16),
        .HALF_H  (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_frame_tick (i_frame_tick),
        .i_cursorX    (i_cursorX),
        .i_cursorY    (i_cursorY),
        .i_streak     (i_streak),
        .i_obj_x      (i_obj_x),
        .i_obj_y      (i_obj_y),
        .i_obj_state  (i_obj_state),
        .hit_bus      (hit_bus),
        .o_scan_busy  (o_scan_busy),
        .o_hit_count  (o_hit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_obj(input int i, input int x, input int y, input obj_state_t st);
        i_obj_x[i*CW +: CW]     = CW'(x);
        i_obj_y[i*CW +: CW]     = CW'(y);
        i_obj_state[i*SW +: SW] = SW'(st);
    endtask

    task automatic clear_objs;
        i_obj_x     = '0;
        i_obj_y     = '0;
        i_obj_state = '0;
    endtask

    // Called at a falling edge; returns in cycle t+1 of a tick raised in cycle t.
    task automatic start_scan;
        i_frame_tick = 1'b1;
        cyc(1);
        i_frame_tick = 1'b0;
    endtask

    task automatic ack;
        hit_bus.hit_ack = 1'b1;
        cyc(1);
        hit_bus.hit_ack = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        i_frame_tick    = 1'b0;
        i_cursorX       = CW'(100);
        i_cursorY       = CW'(100);
        i_streak        = 1'b1;
        hit_bus.hit_ack = 1'b0;
        clear_objs();
        cyc(2);
        check("rst_mask",  32'(hit_bus.hit_mask), 32'h0);
        check("rst_valid", 32'(hit_bus.hit_valid), 32'h0);
        check("rst_busy",  32'(o_scan_busy), 32'h0);
        check("rst_count", 32'(o_hit_count), 32'h0);
        reset = 1'b0;
        cyc(1);

        // Basic hit on obj0 with latency and busy window.
        set_obj(0, 110, 95, ST_LIVE);
        start_scan();
        check("t1_busy_t1",  32'(o_scan_busy), 32'h1);
        cyc(1);
        check("t1_mask_t2",  32'(hit_bus.hit_mask), 32'h00);
        cyc(1);
        check("t1_mask_t3",  32'(hit_bus.hit_mask), 32'h01);
        check("t1_valid_t3", 32'(hit_bus.hit_valid), 32'h1);
        check("t1_count",    32'(o_hit_count), 32'd1);
        cyc(6);
        check("t1_busy_t9",  32'(o_scan_busy), 32'h1);
        cyc(1);
        check("t1_busy_t10", 32'(o_scan_busy), 32'h0);
        ack();
        check("t1_ack_mask",  32'(hit_bus.hit_mask), 32'h0);
        check("t1_ack_valid", 32'(hit_bus.hit_valid), 32'h0);

        // No streak -> no hit.
        i_streak = 1'b0;
        start_scan();
        cyc(9);
        check("nostreak_mask",  32'(hit_bus.hit_mask), 32'h0);
        check("nostreak_count", 32'(o_hit_count), 32'd1);

        // Sliced object -> no hit.
        i_streak = 1'b1;
        set_obj(0, 110, 95, ST_SLICED);
        start_scan();
        cyc(9);
        check("sliced_mask", 32'(hit_bus.hit_mask), 32'h0);

        // Corner of the box on obj3: |dx|=16, |dy|=16.
        clear_objs();
        set_obj(3, 116, 84, ST_LIVE);
        start_scan();
        cyc(4);
        check("corner_mask_t5", 32'(hit_bus.hit_mask), 32'h00);
        cyc(1);
        check("corner_mask_t6", 32'(hit_bus.hit_mask), 32'h08);
        cyc(4);
        check("corner_count", 32'(o_hit_count), 32'd2);
        ack();

        // One pixel outside in x.
        set_obj(3, 117, 100, ST_LIVE);
        start_scan();
        cyc(9);
        check("outside_mask",  32'(hit_bus.hit_mask), 32'h0);
        check("outside_count", 32'(o_hit_count), 32'd2);

        // Near origin: (0,0) hits, (1020,1020) must not wrap into a hit.
        i_cursorX = CW'(5);
        i_cursorY = CW'(5);
        set_obj(3, 0, 0, ST_LIVE);
        set_obj(4, 1020, 1020, ST_LIVE);
        start_scan();
        cyc(9);
        check("nowrap_mask",  32'(hit_bus.hit_mask), 32'h08);
        check("nowrap_count", 32'(o_hit_count), 32'd3);
        ack();

        // Ack in the same cycle obj5 is detected.
        i_cursorX = CW'(100);
        i_cursorY = CW'(100);
        clear_objs();
        set_obj(0, 100, 100, ST_LIVE);
        set_obj(5, 100, 100, ST_LIVE);
        start_scan();
        cyc(6);
        check("race_mask_t7", 32'(hit_bus.hit_mask), 32'h01);
        hit_bus.hit_ack = 1'b1;
        cyc(1);
        hit_bus.hit_ack = 1'b0;
        check("race_mask_t8",  32'(hit_bus.hit_mask), 32'h20);
        check("race_valid_t8", 32'(hit_bus.hit_valid), 32'h1);
        cyc(2);
        check("race_count", 32'(o_hit_count), 32'd5);
        ack();
        check("race_ack_mask", 32'(hit_bus.hit_mask), 32'h0);
        ack();
        check("idle_ack_mask",  32'(hit_bus.hit_mask), 32'h0);
        check("idle_ack_valid", 32'(hit_bus.hit_valid), 32'h0);

        // Tick while busy is dropped: exactly 9 busy cycles.
        clear_objs();
        start_scan();
        busy_n = 0;
        for (int k = 1; k <= 20; k++) begin
            i_frame_tick = (k == 4);
            busy_n += int'(o_scan_busy);
            cyc(1);
        end
        i_frame_tick = 1'b0;
        check("busy_cycles", 32'(busy_n), 32'd9);
        check("busy_after",  32'(o_scan_busy), 32'h0);

        // Reset in the middle of a scan.
        set_obj(0, 100, 100, ST_LIVE);
        start_scan();
        cyc(2);
        check("midrst_mask_t3", 32'(hit_bus.hit_mask), 32'h01);
        cyc(2);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        check("midrst_mask",  32'(hit_bus.hit_mask), 32'h0);
        check("midrst_valid", 32'(hit_bus.hit_valid), 32'h0);
        check("midrst_busy",  32'(o_scan_busy), 32'h0);
        check("midrst_count", 32'(o_hit_count), 32'd0);
        cyc(1);
        check("midrst_idle", 32'(o_scan_busy), 32'h0);

        // Saturation, with live inputs changed after the snapshot.
        force dut.r_hit_count = 16'hFFFE;
        cyc(1);
        release dut.r_hit_count;
        check("sat_preload", 32'(o_hit_count), 32'hFFFE);
        clear_objs();
        set_obj(0, 100, 100, ST_LIVE);
        set_obj(1, 100, 100, ST_LIVE);
        start_scan();
        cyc(1);
        clear_objs();
        cyc(8);
        check("sat_mask",  32'(hit_bus.hit_mask), 32'h03);
        check("sat_count", 32'(o_hit_count), 32'hFFFF);
        ack();

        // Off-screen cursor never hits.
        i_cursorX = CW'(700);
        set_obj(0, 700, 100, ST_LIVE);
        start_scan();
        cyc(9);
        check("offscreen_mask",  32'(hit_bus.hit_mask), 32'h0);
        check("offscreen_count", 32'(o_hit_count), 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
